bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to BCD converter
// with optional two's complement input and saturating overflow.
//
// Ports:
//   i_Clk      clock, rising edge
//   i_Rst      synchronous active-high reset
//   i_Start    conversion request, taken only when idle
//   i_Binary   WIDTH-bit value, captured with an accepted start
//   i_Signed   1 = i_Binary is two's complement
//   o_BCD      DIGITS packed BCD digits, digit 0 in bits [3:0]
//   o_Sign     result is negative
//   o_Overflow magnitude does not fit in DIGITS digits
//   o_Busy     conversion in progress (LOAD..DONE)
//   o_DV       one-cycle pulse when the result outputs update
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [WIDTH-1:0]      i_Binary,
  input  logic                  i_Signed,
  output logic [4*DIGITS-1:0]   o_BCD,
  output logic                  o_Sign,
  output logic                  o_Overflow,
  output logic                  o_Busy,
  output logic                  o_DV
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADJUST,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin_q;
  logic              sgn_q;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     digits;
  logic [BW-1:0]     adj;
  logic              neg;
  logic              ovf;
  logic [CW-1:0]     cnt;

  // Digits are adjusted independently; no carry crosses a digit.
  always_comb begin
    adj = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= S_IDLE;
      bin_q      <= '0;
      sgn_q      <= 1'b0;
      mag        <= '0;
      digits     <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
      cnt        <= '0;
      o_BCD      <= '0;
      o_Sign     <= 1'b0;
      o_Overflow <= 1'b0;
      o_Busy     <= 1'b0;
      o_DV       <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_Start) begin
            bin_q  <= i_Binary;
            sgn_q  <= i_Signed;
            o_Busy <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Negating -2^(WIDTH-1) wraps to itself, which is
          // exactly the unsigned magnitude wanted.
          if (sgn_q && bin_q[WIDTH-1]) begin
            mag <= ~bin_q + WIDTH'(1);
            neg <= 1'b1;
          end else begin
            mag <= bin_q;
            neg <= 1'b0;
          end
          digits <= '0;
          ovf    <= 1'b0;
          cnt    <= '0;
          state  <= S_ADJUST;
        end
        S_ADJUST: begin
          digits <= adj;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          {digits, mag} <= {digits[BW-2:0], mag, 1'b0};
          // A bit leaving the top digit means the value
          // needs more digits than we have.
          if (digits[BW-1])
            ovf <= 1'b1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= S_DONE;
          else
            state <= S_ADJUST;
        end
        S_DONE: begin
          o_BCD      <= ovf ? {DIGITS{4'h9}} : digits;
          o_Sign     <= neg;
          o_Overflow <= ovf;
          o_DV       <= 1'b1;
          o_Busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
